// File: rtl/operand_bank.sv
// Operand register bank feeding the ALU: loads WIDTH-bit operands on load-button edges
// and issues the full set through a valid/ready handshake. Optional parity: OPBANK_PARITY_EN.
module operand_bank #(
  parameter int WIDTH    = 8,
  parameter int NUM_REGS = 2,
  parameter int IDX_W    = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [WIDTH-1:0]          sw_input,
  input  logic                      load,
  input  logic [IDX_W-1:0]          sel,
  input  logic                      mode,
  input  logic                      clear,
  output logic [NUM_REGS*WIDTH-1:0] operands,
  output logic [NUM_REGS-1:0]       loaded_mask,
  output logic [IDX_W-1:0]          next_idx,
  output logic                      ops_valid,
  input  logic                      ops_ready
`ifdef OPBANK_PARITY_EN
  ,
  output logic [NUM_REGS-1:0]       op_parity
`endif
);

  typedef enum logic {FILL, ISSUE} state_e;

  localparam logic [IDX_W:0]   NREGS_W  = (IDX_W+1)'(NUM_REGS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REGS - 1);

  state_e               state_q, state_d;
  logic [WIDTH-1:0]     regs_q [NUM_REGS];
  logic [WIDTH-1:0]     regs_d [NUM_REGS];
  logic [NUM_REGS-1:0]  mask_q, mask_d;
  logic [IDX_W-1:0]     nidx_q, nidx_d;
  logic                 valid_q, valid_d;
  logic                 load_q;

  logic                 load_evt;
  logic [IDX_W-1:0]     target;
  logic                 target_ok;

  assign load_evt  = load & ~load_q;
  assign target    = mode ? nidx_q : sel;
  assign target_ok = ({1'b0, target} < NREGS_W);

  always_comb begin
    state_d = state_q;
    regs_d  = regs_q;
    mask_d  = mask_q;
    nidx_d  = nidx_q;
    valid_d = valid_q;
    if (clear) begin
      state_d = FILL;
      regs_d  = '{default: '0};
      mask_d  = '0;
      nidx_d  = '0;
      valid_d = 1'b0;
    end else begin
      case (state_q)
        FILL: begin
          if (load_evt && target_ok) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
              if (target == IDX_W'(i)) begin
                regs_d[i] = sw_input;
                mask_d[i] = 1'b1;
              end
            end
            if (mode) nidx_d = (nidx_q == LAST_IDX) ? '0 : nidx_q + 1'b1;
            // ops_valid rises on the following cycle, from the ISSUE branch
            if (mask_d == '1) state_d = ISSUE;
          end
        end
        ISSUE: begin
          if (valid_q && ops_ready) begin
            state_d = FILL;
            mask_d  = '0;
            nidx_d  = '0;
            valid_d = 1'b0;
          end else begin
            valid_d = 1'b1;
          end
        end
        default: state_d = FILL;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FILL;
      regs_q  <= '{default: '0};
      mask_q  <= '0;
      nidx_q  <= '0;
      valid_q <= 1'b0;
      load_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      regs_q  <= regs_d;
      mask_q  <= mask_d;
      nidx_q  <= nidx_d;
      valid_q <= valid_d;
      load_q  <= load;
    end
  end

`ifdef OPBANK_PARITY_EN
  logic [NUM_REGS-1:0] par_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_q <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_REGS; i++) par_q[i] <= ^regs_d[i];
    end
  end

  assign op_parity = par_q;
`endif

  always_comb begin
    operands = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) operands[i*WIDTH +: WIDTH] = regs_q[i];
  end

  assign loaded_mask = mask_q;
  assign next_idx    = nidx_q;
  assign ops_valid   = valid_q;

endmodule

// File: tb/tb_operand_bank.sv
// Self-checking bench for operand_bank (3 registers): directed steps then random stimulus,
// compared each cycle against a behavioural model of the operand bank.
module tb_operand_bank;
  localparam int W  = 8;
  localparam int N  = 3;
  localparam int IW = 2;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [W-1:0]     sw_input = '0;
  logic             load = 1'b0;
  logic [IW-1:0]    sel = '0;
  logic             mode = 1'b0;
  logic             clear = 1'b0;
  logic [N*W-1:0]   operands;
  logic [N-1:0]     loaded_mask;
  logic [IW-1:0]    next_idx;
  logic             ops_valid;
  logic             ops_ready = 1'b0;
`ifdef OPBANK_PARITY_EN
  logic [N-1:0]     op_parity;
`endif

  operand_bank #(.WIDTH(W), .NUM_REGS(N), .IDX_W(IW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .sw_input    (sw_input),
    .load        (load),
    .sel         (sel),
    .mode        (mode),
    .clear       (clear),
    .operands    (operands),
    .loaded_mask (loaded_mask),
    .next_idx    (next_idx),
    .ops_valid   (ops_valid),
    .ops_ready   (ops_ready)
`ifdef OPBANK_PARITY_EN
    ,
    .op_parity   (op_parity)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Behavioural model: operand values, set of loaded slots, write pointer, issue flags
  int unsigned m_regs [N];
  bit          m_loaded [N];
  int          m_ptr;
  bit          m_waiting;
  bit          m_valid;
  bit          m_prev_load;

  function automatic void model_reset();
    for (int i = 0; i < N; i++) begin
      m_regs[i] = 0;
      m_loaded[i] = 1'b0;
    end
    m_ptr = 0;
    m_waiting = 1'b0;
    m_valid = 1'b0;
    m_prev_load = 1'b0;
  endfunction

  function automatic void model_step();
    bit evt;
    bit all;
    int t;
    evt = load && !m_prev_load;
    m_prev_load = load;
    if (clear) begin
      for (int i = 0; i < N; i++) begin
        m_regs[i] = 0;
        m_loaded[i] = 1'b0;
      end
      m_ptr = 0;
      m_waiting = 1'b0;
      m_valid = 1'b0;
    end else if (m_waiting) begin
      if (m_valid && ops_ready) begin
        for (int i = 0; i < N; i++) m_loaded[i] = 1'b0;
        m_ptr = 0;
        m_waiting = 1'b0;
        m_valid = 1'b0;
      end else begin
        m_valid = 1'b1;
      end
    end else if (evt) begin
      t = mode ? m_ptr : int'(sel);
      if (t < N) begin
        m_regs[t] = int'(sw_input);
        m_loaded[t] = 1'b1;
        if (mode) m_ptr = (m_ptr + 1) % N;
        all = 1'b1;
        for (int i = 0; i < N; i++) all = all && m_loaded[i];
        m_waiting = all;
      end
    end
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    logic [N*W-1:0] eo;
    logic [N-1:0]   em;
    logic [N-1:0]   ep;
    logic [W-1:0]   v;
    for (int i = 0; i < N; i++) begin
      v = m_regs[i][W-1:0];
      eo[i*W +: W] = v;
      em[i] = m_loaded[i];
      ep[i] = ^v;
    end
    chk({tag, "_operands"}, 64'(operands), 64'(eo));
    chk({tag, "_mask"}, 64'(loaded_mask), 64'(em));
    chk({tag, "_next_idx"}, 64'(next_idx), 64'(m_ptr));
    chk({tag, "_ops_valid"}, 64'(ops_valid), 64'(m_valid));
`ifdef OPBANK_PARITY_EN
    chk({tag, "_parity"}, 64'(op_parity), 64'(ep));
`endif
  endtask

  task automatic cycle(input string tag);
    @(posedge clk);
    if (rst_n) model_step();
    #1;
    check_all(tag);
  endtask

  task automatic pulse(input logic [W-1:0] v, input logic m, input logic [IW-1:0] s, input string tag);
    sw_input = v;
    mode = m;
    sel = s;
    load = 1'b1;
    cycle(tag);
    load = 1'b0;
    cycle(tag);
  endtask

  initial begin
    model_reset();
    #12;
    check_all("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Direct loads fill all three registers; valid one cycle after the last write
    pulse(8'h3C, 1'b0, 2'd0, "t1_a");
    chk("t1_mask01", 64'(loaded_mask), 64'h1);
    pulse(8'hA5, 1'b0, 2'd1, "t1_b");
    chk("t1_ops", 64'(operands), 64'h00A53C);
    sw_input = 8'h5A; sel = 2'd2; load = 1'b1;
    cycle("t1_c");
    chk("t1_valid_lag", 64'(ops_valid), 64'h0);
    load = 1'b0;
    cycle("t1_d");
    chk("t1_valid", 64'(ops_valid), 64'h1);

    // Loads ignored while waiting for the handshake
    for (int i = 0; i < 5; i++) pulse(8'hFF, 1'b0, 2'(i % 3), "t2_hold");
    chk("t2_ops_stable", 64'(operands), 64'h5AA53C);
    ops_ready = 1'b1;
    cycle("t2_hs");
    ops_ready = 1'b0;
    chk("t2_mask_clr", 64'(loaded_mask), 64'h0);
    chk("t2_ops_kept", 64'(operands), 64'h5AA53C);

    // Sequential loads with pointer wrap
    pulse(8'h11, 1'b1, 2'd0, "t3_a");
    chk("t3_ptr1", 64'(next_idx), 64'h1);
    pulse(8'h22, 1'b1, 2'd0, "t3_b");
    pulse(8'h33, 1'b1, 2'd0, "t3_c");
    chk("t3_ops", 64'(operands), 64'h332211);
    chk("t3_ptr_wrap", 64'(next_idx), 64'h0);
    ops_ready = 1'b1;
    cycle("t3_hs");
    ops_ready = 1'b0;

    // Held load gives one event; out-of-range direct select is ignored
    sw_input = 8'h77; mode = 1'b1; load = 1'b1;
    for (int i = 0; i < 20; i++) cycle("t4_held");
    load = 1'b0;
    cycle("t4_rel");
    chk("t4_ptr", 64'(next_idx), 64'h1);
    chk("t4_mask", 64'(loaded_mask), 64'h1);
    pulse(8'hEE, 1'b0, 2'd3, "t4_sel3");
    chk("t4_sel3_mask", 64'(loaded_mask), 64'h1);

    // Clear wins over a coincident load event and a coincident handshake
    sw_input = 8'h99; sel = 2'd1; mode = 1'b0; load = 1'b1; clear = 1'b1;
    cycle("t5_clr_load");
    clear = 1'b0; load = 1'b0;
    chk("t5_ops_zero", 64'(operands), 64'h0);
    pulse(8'h01, 1'b0, 2'd0, "t5_f0");
    pulse(8'h02, 1'b0, 2'd1, "t5_f1");
    pulse(8'h03, 1'b0, 2'd2, "t5_f2");
    ops_ready = 1'b1; clear = 1'b1;
    cycle("t5_clr_hs");
    ops_ready = 1'b0; clear = 1'b0;
    chk("t5_valid_zero", 64'(ops_valid), 64'h0);
    pulse(8'h44, 1'b1, 2'd0, "t5_pre_rst");
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all("t5_async_rst");
    @(negedge clk);
    rst_n = 1'b1;

    // Parity of reg0=0x07 (odd) and reg1=0x03 (even)
    pulse(8'h07, 1'b0, 2'd0, "t6_a");
    pulse(8'h03, 1'b0, 2'd1, "t6_b");
`ifdef OPBANK_PARITY_EN
    chk("t6_parity", 64'(op_parity), 64'h1);
`endif

    // Random stimulus
    for (int i = 0; i < 600; i++) begin
      sw_input  = W'($urandom);
      load      = ($urandom_range(0, 2) == 0) ? ~load : load;
      mode      = 1'($urandom_range(0, 1));
      sel       = IW'($urandom_range(0, 3));
      clear     = ($urandom_range(0, 39) == 0);
      ops_ready = 1'($urandom_range(0, 1));
      cycle("rnd");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/operand_bank.md
Name: operand_bank

Overview:
Parametrised successor to the two-register A/B operand latch feeding the Lab3 ALU.
- Holds NUM_REGS operands of WIDTH bits, loaded from the switch bus on the rising edge of a debounced load button, by direct index or sequential auto-index.
- Tracks which operands are loaded and presents the full set to the ALU through a valid/ready handshake.
- Sits between the button/switch input stage and the ALU controller.

Parameters:
WIDTH, 8, operand width in bits
NUM_REGS, 2, number of operand registers (>=2)
IDX_W, 1, index width; must satisfy 2**IDX_W >= NUM_REGS

Ports:
clk  in  1  system clock
rst_n  in  1  reset; asynchronous, active-low
sw_input  in  WIDTH  switch value to load
load  in  1  debounced load button level; block edge-detects it
sel  in  IDX_W  target register in direct mode
mode  in  1  0 = direct (use sel), 1 = sequential (use next_idx)
clear  in  1  synchronous clear of registers and state
operands  out  NUM_REGS*WIDTH  flat bus; register i at bits [i*WIDTH +: WIDTH]
loaded_mask  out  NUM_REGS  bit i set when register i loaded since last issue/clear
next_idx  out  IDX_W  sequential write pointer
ops_valid  out  1  full operand set available
ops_ready  in  1  ALU accepts operand set

Behaviour:
- Reset (rst_n low, async): all registers 0, loaded_mask 0, next_idx 0, ops_valid 0, state FILL, load_q 0.
- Edge detect: load_q <= load each cycle; load_evt = load & ~load_q. Holding load high gives one event only.
- Target index: sel when mode=0, next_idx when mode=1.
- State FILL:
  - On load_evt, register[target] <= sw_input and loaded_mask[target] <= 1. Value visible on operands the next cycle.
  - Overwriting an already-loaded register is allowed; the mask bit stays 1.
  - Direct mode with sel >= NUM_REGS: event ignored; no register, mask or pointer change.
  - Sequential mode: next_idx increments after each accepted load and wraps from NUM_REGS-1 to 0.
  - Direct-mode loads do not move next_idx.
  - Transition to ISSUE in the cycle the mask becomes all-ones. ops_valid is registered high from the next cycle, i.e. one cycle after the last operand appears.
- State ISSUE:
  - ops_valid = 1 and is held until handshake. Operands are stable; all load events are ignored.
  - On ops_valid & ops_ready: loaded_mask <= 0, next_idx <= 0, ops_valid <= 0 next cycle, return to FILL.
  - Register contents are retained after issue; only the mask clears.
  - ops_ready while ops_valid is low has no effect.
- clear:
  - Highest synchronous priority, in any state: registers 0, mask 0, next_idx 0, ops_valid 0, state FILL.
  - A coincident load_evt or handshake is discarded.
  - The edge detector still samples load, so a button held through clear produces no event afterwards.
- Async reset mid-operation: immediate return to reset values; no partial state survives.
- mode may change at any cycle; it takes effect on the next load_evt.

Optional Feature:
Macro: OPBANK_PARITY_EN
- Defined:
  - Adds output port op_parity [NUM_REGS-1:0]; bit i = XOR-reduction (even parity) of register i.
  - Registered, updated in the same cycle as the register write; reset and clear value 0.
- Undefined:
  - Port and logic absent; all other behaviour identical.

Test Plan:
1. Reset, mode=0, sel=0, sw=0x3C, load pulse; sel=1, sw=0xA5, load pulse -> operands=0xA53C, mask 01 then 11, ops_valid high one cycle after second write.
2. ops_valid high with ops_ready=0 for 5 cycles, load pulses with sw=0xFF -> operands stay 0xA53C, ops_valid held. Then ops_ready=1 -> mask=00, ops_valid=0 next cycle, operands still 0xA53C.
3. NUM_REGS=3, mode=1, loads of 0x11, 0x22, 0x33 -> next_idx 0->1->2->0, operands=0x332211, ops_valid asserted.
4. load held high 20 cycles, mode=1 -> exactly one write, next_idx=1. Direct mode sel=3 with NUM_REGS=3 -> no change.
5. clear asserted in same cycle as load_evt and as ops_ready handshake -> all registers 0, mask 0, ops_valid 0, no write. rst_n low mid-FILL -> outputs 0 immediately, without a clock edge.
6. OPBANK_PARITY_EN defined, load 0x07 to reg 0 and 0x03 to reg 1 -> op_parity=01.
